out_glb_deskew: RTL and testbench
=================================

OUT_GLB_DESKEW -- requirements
Module: out_glb_deskew

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one column result word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: entries per column FIFO (power of two, at least 2).
REQ-003 SHALL have parameter PE_SIZE, default 16: number of array columns and column FIFOs.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port wren_i, input, 1: write strobe aligned to column 0 of the skewed array output.
REQ-007 SHALL have port wdata_i, input, DATA_WIDTH*PE_SIZE: skewed column results; column j at bits [DATA_WIDTH*(PE_SIZE-1-j) +: DATA_WIDTH].
REQ-008 SHALL have port rden_i, input, 1: request to pop one aligned row.
REQ-009 SHALL have port rdata_o, output, DATA_WIDTH*PE_SIZE: aligned row, same column packing as wdata_i.
REQ-010 SHALL have port rvalid_o, output, 1: rdata_o holds a newly popped row.
REQ-011 SHALL have port row_avail_o, output, 1: every column FIFO is non-empty.
REQ-012 SHALL have port full_o, output, PE_SIZE: per-column FIFO full.
REQ-013 SHALL have port empty_o, output, PE_SIZE: per-column FIFO empty.
REQ-014 SHALL have port ovf_o, output, 1: sticky overflow error.
REQ-015 SHALL have port udf_o, output, 1: sticky underflow error.

Function
REQ-016 Deskew: column j write enable SHALL be wren_i delayed by exactly j cycles; column 0 undelayed, PE_SIZE-1 delay registers.
REQ-017 Column j SHALL capture its wdata_i slice in the cycle its delayed write enable is high.
REQ-018 row_avail_o SHALL be the AND of all inverted empty_o bits, combinational from FIFO state.
REQ-019 A pop SHALL be accepted when rden_i and row_avail_o are both high; all columns pop in the same cycle.
REQ-020 rdata_o and rvalid_o SHALL be registered: one-cycle latency after the accepting cycle; rvalid_o is a single-cycle pulse per pop.
REQ-021 rdata_o SHALL hold its last value when no pop is accepted.
REQ-022 rden_i while row_avail_o is low SHALL pop nothing, leave rvalid_o low, and set udf_o.
REQ-023 A write to a full column SHALL be dropped for that column only and SHALL set ovf_o; the other columns are unaffected.
REQ-024 A simultaneous accepted pop and write on a full column SHALL succeed without overflow; occupancy is unchanged.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL span 0..FIFO_DEPTH without aliasing.
REQ-026 ovf_o and udf_o SHALL stay set until reset.

Reset
REQ-027 While rst is high at a clock edge, the following SHALL be cleared: all deskew delay registers, FIFO pointers and counts, rdata_o, rvalid_o, ovf_o and udf_o.
REQ-028 After reset, empty_o SHALL be all ones, full_o zero, and row_avail_o zero.
REQ-029 Reset mid-operation SHALL discard in-flight skewed writes; no column receives a write for the first PE_SIZE-1 cycles after reset unless wren_i is asserted after reset.

Structure
REQ-030 Default widths and depth constants SHALL reside in the shared GEMM parameter package.
REQ-031 Each column SHALL be one instance of the existing FIFO sub-module (synchronous active-high reset variant); deskew, pop control and flags live in out_glb_deskew.

Verification (PE_SIZE=4, DATA_WIDTH=8, FIFO_DEPTH=4)
REQ-032 The bench SHALL cover skewed single row: wren_i pulsed at t0; column j data 0x10+j presented at t0+j; then rden_i. Required response: row_avail_o high at t0+4, and rdata_o=0x10111213 with rvalid_o one cycle after the pop.
REQ-033 The bench SHALL cover streaming: wren_i high 4 cycles with skewed rows 0..3 presented, then rden_i high 4 cycles. Required response: 4 rvalid_o pulses with rows in order, empty_o=4'hF afterwards, ovf_o=0.
REQ-034 The bench SHALL cover overflow: 5 rows written with no reads. Required response: full_o=4'hF, ovf_o=1, and the first 4 rows are read back intact.
REQ-035 The bench SHALL cover underflow: rden_i while empty. Required response: no rvalid_o, udf_o=1, rdata_o unchanged.
REQ-036 The bench SHALL cover full plus simultaneous pop: 4 rows written, then a pop in the same cycle as the 5th row's column-0 write. Required response: ovf_o stays 0 and the 5th row is read last.
REQ-037 The bench SHALL cover reset mid-skew: rst asserted at t0+1 after a wren_i pulse. Required response: empty_o=4'hF for all later cycles and flags are 0.

Source files
------------

// File: rtl/out_glb_deskew_pkg.sv
// Shared GEMM parameters for the output global-buffer deskew path.
// Default widths and FIFO geometry, plus a pointer-width helper.
package out_glb_deskew_pkg;

    localparam int GEMM_DATA_WIDTH = 32;
    localparam int GEMM_FIFO_DEPTH = 16;
    localparam int GEMM_PE_SIZE    = 16;

    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/out_glb_deskew_fifo.sv
// Single-column synchronous FIFO, active-high synchronous reset.
// Head word is visible combinationally; drop flags a refused write.
module out_glb_deskew_fifo
    import out_glb_deskew_pkg::*;
#(
    parameter int DATA_WIDTH = GEMM_DATA_WIDTH,
    parameter int FIFO_DEPTH = GEMM_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  drop
);

    localparam int AW = ptr_bits(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  do_rd;
    logic                  do_wr;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign do_rd = rd_en && !empty;
    // A full column still accepts a write when it pops in the same cycle.
    assign do_wr = wr_en && (!full || do_rd);
    assign drop  = wr_en && full && !do_rd;

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/out_glb_deskew.sv
// Realigns skewed systolic-array column results into whole rows,
// one FIFO per column, with row-wide pop and sticky error flags.
module out_glb_deskew
    import out_glb_deskew_pkg::*;
#(
    parameter int DATA_WIDTH = GEMM_DATA_WIDTH,
    parameter int FIFO_DEPTH = GEMM_FIFO_DEPTH,
    parameter int PE_SIZE    = GEMM_PE_SIZE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wren_i,
    input  logic [DATA_WIDTH*PE_SIZE-1:0] wdata_i,
    input  logic                          rden_i,
    output logic [DATA_WIDTH*PE_SIZE-1:0] rdata_o,
    output logic                          rvalid_o,
    output logic                          row_avail_o,
    output logic [PE_SIZE-1:0]            full_o,
    output logic [PE_SIZE-1:0]            empty_o,
    output logic                          ovf_o,
    output logic                          udf_o
);

    localparam int RW = DATA_WIDTH * PE_SIZE;

    logic [PE_SIZE-2:0] dly;
    logic [PE_SIZE-1:0] col_we;
    logic [PE_SIZE-1:0] col_drop;
    logic [RW-1:0]      heads;
    logic               pop;

    // dly[k] is wren_i delayed k+1 cycles, feeding column k+1.
    assign col_we      = {dly, wren_i};
    assign row_avail_o = &(~empty_o);
    assign pop         = rden_i && row_avail_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            dly <= '0;
        end else begin
            dly[0] <= wren_i;
            for (int k = 1; k < PE_SIZE - 1; k++) begin
                dly[k] <= dly[k-1];
            end
        end
    end

    for (genvar j = 0; j < PE_SIZE; j++) begin : g_col
        out_glb_deskew_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (col_we[j]),
            .wr_data (wdata_i[DATA_WIDTH*(PE_SIZE-1-j) +: DATA_WIDTH]),
            .rd_en   (pop),
            .rd_data (heads[DATA_WIDTH*(PE_SIZE-1-j) +: DATA_WIDTH]),
            .full    (full_o[j]),
            .empty   (empty_o[j]),
            .drop    (col_drop[j])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
            ovf_o    <= 1'b0;
            udf_o    <= 1'b0;
        end else begin
            rvalid_o <= pop;
            if (pop) rdata_o <= heads;
            if (|col_drop) ovf_o <= 1'b1;
            if (rden_i && !row_avail_o) udf_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_out_glb_deskew.sv
// Bench for out_glb_deskew: directed skew scenarios plus random traffic
// against a queue-per-column reference model.
module tb_out_glb_deskew;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int PE    = 4;
    localparam int W     = DW * PE;

    logic          clk = 1'b0;
    logic          rst;
    logic          wren_i;
    logic [W-1:0]  wdata_i;
    logic          rden_i;
    logic [W-1:0]  rdata_o;
    logic          rvalid_o;
    logic          row_avail_o;
    logic [PE-1:0] full_o;
    logic [PE-1:0] empty_o;
    logic          ovf_o;
    logic          udf_o;

    always #5 clk = ~clk;

    out_glb_deskew #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .PE_SIZE    (PE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wren_i      (wren_i),
        .wdata_i     (wdata_i),
        .rden_i      (rden_i),
        .rdata_o     (rdata_o),
        .rvalid_o    (rvalid_o),
        .row_avail_o (row_avail_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .ovf_o       (ovf_o),
        .udf_o       (udf_o)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_rst = -1000;

    bit [DW-1:0] mq [PE][$];
    bit          we_hist [int];
    bit          esched [int];
    logic [W-1:0] dsched [int];

    logic [W-1:0] exp_rdata;
    bit           exp_rvalid;
    bit           exp_ovf;
    bit           exp_udf;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Schedule a row whose column j word appears on the bus j cycles after t.
    task automatic plan_row(input int t, input logic [W-1:0] row);
        logic [W-1:0] v;
        esched[t] = 1'b1;
        for (int j = 0; j < PE; j++) begin
            v = dsched.exists(t + j) ? dsched[t + j] : W'($urandom);
            v[DW*(PE-1-j) +: DW] = row[DW*(PE-1-j) +: DW];
            dsched[t + j] = v;
        end
    endtask

    task automatic model(input bit r, input bit we, input logic [W-1:0] wd,
                         input bit rd, input int c);
        int  sz [PE];
        bit  avail;
        bit  pop;
        int  src;
        we_hist[c] = we;
        if (r) begin
            for (int j = 0; j < PE; j++) mq[j].delete();
            exp_rdata  = '0;
            exp_rvalid = 1'b0;
            exp_ovf    = 1'b0;
            exp_udf    = 1'b0;
            last_rst   = c;
        end else begin
            avail = 1'b1;
            for (int j = 0; j < PE; j++) begin
                sz[j] = mq[j].size();
                if (sz[j] == 0) avail = 1'b0;
            end
            pop = rd && avail;
            if (rd && !avail) exp_udf = 1'b1;
            exp_rvalid = pop;
            if (pop) begin
                for (int j = 0; j < PE; j++)
                    exp_rdata[DW*(PE-1-j) +: DW] = mq[j].pop_front();
            end
            for (int j = 0; j < PE; j++) begin
                src = c - j;
                if (src > last_rst && we_hist.exists(src) && we_hist[src]) begin
                    if (sz[j] == DEPTH && !pop) exp_ovf = 1'b1;
                    else mq[j].push_back(wd[DW*(PE-1-j) +: DW]);
                end
            end
        end
    endtask

    task automatic tick(input bit r, input bit rd, input bit we_force);
        bit            we;
        logic [W-1:0]  wd;
        logic [PE-1:0] e_empty;
        logic [PE-1:0] e_full;
        we = esched.exists(cyc) || we_force;
        wd = dsched.exists(cyc) ? dsched[cyc] : W'($urandom);
        rst     = r;
        wren_i  = we;
        wdata_i = wd;
        rden_i  = rd;
        @(posedge clk);
        #1;
        model(r, we, wd, rd, cyc);
        for (int j = 0; j < PE; j++) begin
            e_empty[j] = (mq[j].size() == 0);
            e_full[j]  = (mq[j].size() == DEPTH);
        end
        chk("m_rvalid", rvalid_o, exp_rvalid);
        chk("m_rdata", rdata_o, exp_rdata);
        chk("m_ovf", ovf_o, exp_ovf);
        chk("m_udf", udf_o, exp_udf);
        chk("m_empty", empty_o, e_empty);
        chk("m_full", full_o, e_full);
        chk("m_avail", row_avail_o, &(~e_empty));
        cyc++;
    endtask

    logic [W-1:0] rows [5];
    int t0;

    initial begin
        rst = 1'b1; wren_i = 1'b0; wdata_i = '0; rden_i = 1'b0;

        tick(1, 0, 0);
        tick(1, 0, 0);
        chk("rst_empty", empty_o, 4'hF);
        chk("rst_full", full_o, 4'h0);
        chk("rst_avail", row_avail_o, 1'b0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_flags", {rvalid_o, ovf_o, udf_o}, 3'b000);

        // single skewed row
        t0 = cyc;
        plan_row(t0, 32'h10111213);
        repeat (3) tick(0, 0, 0);
        chk("single_avail_early", row_avail_o, 1'b0);
        tick(0, 0, 0);
        chk("single_avail", row_avail_o, 1'b1);
        tick(0, 1, 0);
        chk("single_rvalid", rvalid_o, 1'b1);
        chk("single_rdata", rdata_o, 32'h10111213);
        tick(0, 0, 0);
        chk("single_pulse", rvalid_o, 1'b0);
        chk("single_hold", rdata_o, 32'h10111213);

        // streaming four rows
        t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            rows[k] = W'($urandom);
            plan_row(t0 + k, rows[k]);
        end
        repeat (7) tick(0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick(0, 1, 0);
            chk("stream_rvalid", rvalid_o, 1'b1);
            chk("stream_row", rdata_o, rows[k]);
        end
        tick(0, 0, 0);
        chk("stream_empty", empty_o, 4'hF);
        chk("stream_ovf", ovf_o, 1'b0);

        // full with simultaneous pop on the fifth row's column-0 write
        t0 = cyc;
        for (int k = 0; k < 5; k++) rows[k] = W'($urandom);
        for (int k = 0; k < 4; k++) plan_row(t0 + k, rows[k]);
        repeat (7) tick(0, 0, 0);
        chk("fp_full", full_o, 4'hF);
        plan_row(cyc, rows[4]);
        tick(0, 1, 0);
        chk("fp_first", rdata_o, rows[0]);
        for (int k = 1; k < 5; k++) begin
            tick(0, 1, 0);
            chk("fp_rvalid", rvalid_o, 1'b1);
            chk("fp_row", rdata_o, rows[k]);
        end
        chk("fp_ovf", ovf_o, 1'b0);
        chk("fp_empty", empty_o, 4'hF);

        // overflow: five rows, no reads
        t0 = cyc;
        for (int k = 0; k < 5; k++) begin
            rows[k] = W'($urandom);
            plan_row(t0 + k, rows[k]);
        end
        repeat (8) tick(0, 0, 0);
        chk("ovf_full", full_o, 4'hF);
        chk("ovf_flag", ovf_o, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick(0, 1, 0);
            chk("ovf_row", rdata_o, rows[k]);
        end
        chk("ovf_empty", empty_o, 4'hF);

        // underflow on empty
        tick(0, 1, 0);
        chk("udf_rvalid", rvalid_o, 1'b0);
        chk("udf_flag", udf_o, 1'b1);
        chk("udf_rdata", rdata_o, rows[3]);
        tick(0, 0, 0);
        chk("udf_sticky", udf_o, 1'b1);

        // reset in the middle of a skewed write
        tick(1, 0, 0);
        tick(0, 0, 1);
        tick(1, 0, 0);
        repeat (8) begin
            tick(0, 0, 0);
            chk("rsk_empty", empty_o, 4'hF);
            chk("rsk_flags", {ovf_o, udf_o}, 2'b00);
        end

        // random traffic: write-heavy, then read-heavy
        tick(1, 0, 0);
        repeat (200) tick(0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0);
        repeat (200) tick(0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
        tick(1, 0, 0);
        repeat (200) tick(0, $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
